sipo_deserializer: RTL

Serial-in, parallel-out receiver that reassembles MSB-first serial words produced by the team's PISO transmitter into parallel words. Bits are qualified by a strobe and accumulated by a bit counter. Completed words are parked in an output holding register behind a valid/ready handshake, so downstream logic can stall without corrupting a frame in progress. It sits at the receive end of the serial link, between the line and the word-level consumer.

---
 rtl/sipo_pkg.sv | 19 +
 rtl/sipo_shift_reg.sv | 45 ++++
 rtl/sipo_deserializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer.
// Optional parity framing is enabled with SIPO_PARITY_EN.
package sipo_pkg;

  typedef enum logic {
    RECV = 1'b0,
    PAR  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int PAR_MAX_W     = 64;

  function automatic logic even_parity(
    input logic [PAR_MAX_W-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first shift register and bit counter.
// `word` is the next shift value so a completing bit is included.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (bit_en) begin
      shift_d = {shift_q[WIDTH-2:0], sin};
      done    = (cnt_q == LAST);
      cnt_d   = done ? '0 : cnt_q + 1'b1;
    end
  end

  assign word = shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// SIPO receiver with valid/ready holding register and sticky overrun.
// Define SIPO_PARITY_EN for a trailing even-parity bit per frame.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err
);

  logic             sr_en;
  logic             sr_done;
  logic [WIDTH-1:0] sr_word;

  logic             complete;
  logic [WIDTH-1:0] cword;
  logic             par_bad;

  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .bit_en(sr_en),
    .sin   (sin),
    .word  (sr_word),
    .done  (sr_done)
  );

`ifdef SIPO_PARITY_EN
  state_e state_q, state_d;

  // Shifter is frozen in PAR, so sr_word holds the data word.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    cword    = sr_word;
    par_bad  = 1'b0;
    sr_en    = sin_en && (state_q == RECV);
    unique case (state_q)
      RECV: if (sr_done) state_d = PAR;
      PAR: begin
        if (sin_en) begin
          complete = 1'b1;
          par_bad  = even_parity(PAR_MAX_W'(sr_word)) ^ sin;
          state_d  = RECV;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RECV;
    else        state_q <= state_d;
  end
`else
  always_comb begin
    sr_en    = sin_en;
    complete = sr_done;
    cword    = sr_word;
    par_bad  = 1'b0;
  end
`endif

  always_comb begin
    pout_d  = pout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    if (valid_q && pout_ready) valid_d = 1'b0;
    if (overrun_clr) ovr_d = 1'b0;
    // A drop sets overrun after the clear so set wins.
    if (complete) begin
      if (!valid_q || pout_ready) begin
        pout_d  = cword;
        valid_d = 1'b1;
        perr_d  = par_bad;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule
